piezo_tone_sequencer: RTL and testbench

Parametrised successor tone generator for the piezo path. It accepts tone commands (frequency, duration, trailing gap) over a valid/ready interface and buffers them in an internal FIFO. Each command plays as a square wave followed by a silent gap, so a Morse symbol stream (dot, dash, inter-element space) can be queued without per-tone supervision from the controller. It sits between the Morse encoder/control FSM and the piezo pin.

---
 rtl/piezo_tone_sequencer_if.sv | 27 ++
 rtl/piezo_tone_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_piezo_tone_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piezo_tone_sequencer_if.sv
// Tone command channel: one {freq, dur, gap} command per valid/ready handshake.
interface piezo_tone_sequencer_if #(
    parameter int unsigned FREQ_W = 16,
    parameter int unsigned DUR_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [FREQ_W-1:0] cmd_freq;
    logic [DUR_W-1:0]  cmd_dur;
    logic [DUR_W-1:0]  cmd_gap;

    modport master (
        output cmd_valid,
        output cmd_freq,
        output cmd_dur,
        output cmd_gap,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_freq,
        input  cmd_dur,
        input  cmd_gap,
        output cmd_ready
    );
endinterface

// File: rtl/piezo_tone_sequencer.sv
// Queued piezo tone generator: buffers {freq, dur, gap} commands in a FIFO and
// plays each as a square wave of dur ms followed by gap ms of silence.
module piezo_tone_sequencer #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FREQ_W     = 16,
    parameter int unsigned DUR_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    piezo_tone_sequencer_if.slave       cmd,
    input  logic                        abort,
    output logic                        pwm_out,
    output logic                        busy,
    output logic                        tone_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W     = AW + 1;
    localparam int unsigned TICKS     = CLK_FREQ / 1000;
    localparam int unsigned PRE_W     = $clog2(TICKS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS - 1);
    localparam logic [31:0]  DIVIDEND = 32'(CLK_FREQ / 2);
    localparam logic [4:0]   DIV_LAST = 5'd31;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [DUR_W-1:0]  dur;
        logic [DUR_W-1:0]  gap;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DIV, TONE, GAP} state_t;

    state_t state;
    state_t state_d;

    entry_t            mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    entry_t            work;

    logic [31:0]       rem_r;
    logic [31:0]       quo_r;
    logic [4:0]        div_cnt;
    logic [31:0]       hp_m1;
    logic [31:0]       per_cnt;
    logic [PRE_W-1:0]  pre_cnt;
    logic [DUR_W-1:0]  ms_cnt;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              enter_tone;
    logic              clr_time;
    logic              pwm_d;
    logic              done_d;
    logic              busy_d;
    logic              time_done;
    logic [DUR_W-1:0]  target;

    logic [31:0]       div_c;
    logic [32:0]       rem_sh;
    logic              ge;
    logic [31:0]       r_next;
    logic [31:0]       q_next;
    logic [31:0]       hp_m1_next;

    assign full          = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty         = (fifo_level == '0);
    assign cmd.cmd_ready = !full && !abort;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    // One restoring-divide step per DIV cycle; quotient shifts in from the right.
    assign div_c      = 32'(work.freq);
    assign rem_sh     = {rem_r, quo_r[31]};
    assign ge         = (rem_sh >= {1'b0, div_c});
    assign r_next     = ge ? 32'(rem_sh - {1'b0, div_c}) : rem_sh[31:0];
    assign q_next     = {quo_r[30:0], ge};
    assign hp_m1_next = (q_next == '0) ? '0 : q_next - 32'd1;

    // Elapsed-time compare: exits on the edge that completes target*TICKS cycles;
    // a zero-length target still spends the exit edge in its state.
    assign target    = (state == TONE) ? work.dur : work.gap;
    assign time_done = (target == '0) ||
                       ((pre_cnt == PRE_LAST) &&
                        (({1'b0, ms_cnt} + (DUR_W + 1)'(1)) == {1'b0, target}));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, FIFO pop and next output values.
    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        enter_tone = 1'b0;
        clr_time   = 1'b0;
        pwm_d      = pwm_out;
        done_d     = 1'b0;
        busy_d     = (state != IDLE) || !empty;

        case (state)
            IDLE: begin
                pwm_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                pwm_d = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    clr_time = 1'b1;
                    if (work.dur == '0) begin
                        state_d = GAP;
                    end else begin
                        state_d    = TONE;
                        enter_tone = 1'b1;
                        pwm_d      = (work.freq != '0);
                    end
                end
            end
            TONE: begin
                if (time_done) begin
                    state_d  = GAP;
                    clr_time = 1'b1;
                    pwm_d    = 1'b0;
                end else if ((work.freq != '0) && (per_cnt == hp_m1)) begin
                    pwm_d = !pwm_out;
                end
            end
            GAP: begin
                pwm_d = 1'b0;
                if (time_done) begin
                    done_d = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = DIV;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pwm_d   = 1'b0;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            pop        = 1'b0;
            enter_tone = 1'b0;
            clr_time   = 1'b0;
            pwm_d      = 1'b0;
            done_d     = 1'b0;
            busy_d     = 1'b0;
        end
    end

    // Command storage; payload needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{freq: cmd.cmd_freq, dur: cmd.cmd_dur, gap: cmd.cmd_gap};
        end
    end

    // FIFO pointers/occupancy, registered outputs and tone datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            pwm_out    <= 1'b0;
            tone_done  <= 1'b0;
            busy       <= 1'b0;
            work       <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            div_cnt    <= '0;
            hp_m1      <= '0;
            per_cnt    <= '0;
            pre_cnt    <= '0;
            ms_cnt     <= '0;
        end else begin
            pwm_out   <= pwm_d;
            tone_done <= done_d;
            busy      <= busy_d;

            if (abort) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
            end

            if (pop) begin
                work    <= mem[rd_ptr];
                rem_r   <= '0;
                quo_r   <= DIVIDEND;
                div_cnt <= '0;
            end else if (state == DIV) begin
                rem_r   <= r_next;
                quo_r   <= q_next;
                div_cnt <= div_cnt + 5'd1;
            end

            if (enter_tone) begin
                hp_m1   <= hp_m1_next;
                per_cnt <= '0;
            end else if (state == TONE) begin
                per_cnt <= (per_cnt == hp_m1) ? '0 : per_cnt + 32'd1;
            end

            if (clr_time) begin
                pre_cnt <= '0;
                ms_cnt  <= '0;
            end else if ((state == TONE) || (state == GAP)) begin
                if (pre_cnt == PRE_LAST) begin
                    pre_cnt <= '0;
                    ms_cnt  <= ms_cnt + DUR_W'(1);
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piezo_tone_sequencer.sv
// Scoreboard bench for piezo_tone_sequencer: each accepted command is turned
// into an expected timeline (pop, tone start/end, gap exit) by plain arithmetic;
// a negedge monitor compares every cycle's outputs against that timeline.
module tb_piezo_tone_sequencer;
    localparam int unsigned CLK_FREQ   = 100_000;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FREQ_W     = 16;
    localparam int unsigned DUR_W      = 16;
    localparam int unsigned TICKS      = CLK_FREQ / 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       pwm_out;
    logic       busy;
    logic       tone_done;
    logic [2:0] fifo_level;

    piezo_tone_sequencer_if #(.FREQ_W(FREQ_W), .DUR_W(DUR_W)) cmd_if ();

    piezo_tone_sequencer #(
        .CLK_FREQ  (CLK_FREQ),
        .FIFO_DEPTH(FIFO_DEPTH),
        .FREQ_W    (FREQ_W),
        .DUR_W     (DUR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .abort     (abort),
        .pwm_out   (pwm_out),
        .busy      (busy),
        .tone_done (tone_done),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // cyc = number of posedges so far; at a negedge it names the edge just taken.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected timeline of one command, as edge indices.
    typedef struct {
        int unsigned a;      // accepting edge
        int unsigned p;      // pop edge
        int unsigned t;      // tone start (pwm rises here if audible)
        int unsigned e;      // tone end / gap start
        int unsigned x;      // gap exit, tone_done visible after this edge
        int unsigned f;
        int unsigned hp;
        int unsigned rises;
    } exp_t;

    exp_t        sb[$];
    int unsigned last_exit = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    int unsigned rise_cnt = 0;
    logic        prev_pwm = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        sb.delete();
        last_exit = 0;
    endtask

    // Reference model: start after the previous command exits (or one edge after
    // acceptance), 32 divide cycles, dur ms of tone, gap ms of silence (min one edge).
    task automatic push_model(input int unsigned a, input int unsigned f,
                              input int unsigned d, input int unsigned g);
        exp_t r;
        r.a = a;
        r.f = f;
        r.p = (a + 1 > last_exit) ? a + 1 : last_exit;
        r.t = r.p + 32;
        r.e = r.t + d * TICKS;
        r.x = r.e + ((g == 0) ? 1 : g * TICKS);
        r.hp = (f == 0) ? 1 : (CLK_FREQ / 2) / f;
        if (r.hp == 0) r.hp = 1;
        r.rises = (f == 0 || d == 0) ? 0 : (d * TICKS + 2 * r.hp - 1) / (2 * r.hp);
        last_exit = r.x;
        sb.push_back(r);
    endtask

    task automatic send(input int unsigned f, input int unsigned d, input int unsigned g);
        bit          ok = 1'b0;
        int unsigned a = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_freq  = FREQ_W'(f);
        cmd_if.cmd_dur   = DUR_W'(d);
        cmd_if.cmd_gap   = DUR_W'(g);
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) begin
                ok = 1'b1;
                a  = cyc + 1;
            end
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        if (ok) begin
            push_model(a, f, d, g);
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout at edge %0d: got no cmd_ready expected accept", cyc);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20000 && sb.size() > 0; t++) tick();
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout at edge %0d: got %0d pending expected 0", cyc, sb.size());
        end
        repeat (3) tick();
    endtask

    // Monitor: per-cycle compare of every output, tone summary on tone_done.
    always @(negedge clk) begin
        if (mon_en) begin
            int unsigned occ;
            bit          bsy;
            bit          dn;
            bit          pw;
            occ = 0;
            bsy = 1'b0;
            pw  = 1'b0;
            foreach (sb[i]) begin
                if (sb[i].a <= cyc && cyc < sb[i].p) occ++;
                if (sb[i].a < cyc && cyc <= sb[i].x) bsy = 1'b1;
            end
            dn = (sb.size() > 0) && (sb[0].x == cyc);
            if (sb.size() > 0 && sb[0].f != 0 && sb[0].t <= cyc && cyc < sb[0].e)
                pw = (((cyc - sb[0].t) / sb[0].hp) % 2) == 0;

            check("fifo_level", fifo_level, occ);
            check("cmd_ready", cmd_if.cmd_ready, (occ < FIFO_DEPTH) && !abort);
            check("busy", busy, bsy);
            check("tone_done", tone_done, dn);
            check("pwm_out", pwm_out, pw);

            if (pwm_out && !prev_pwm) rise_cnt++;
            prev_pwm = pwm_out;
            if (tone_done) begin
                if (sb.size() > 0) begin
                    check("rise_count", rise_cnt, sb[0].rises);
                    void'(sb.pop_front());
                end
                rise_cnt = 0;
            end
            if (rst || abort) rise_cnt = 0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog at edge %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_freq  = '0;
        cmd_if.cmd_dur   = '0;
        cmd_if.cmd_gap   = '0;
        repeat (3) tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();

        // Single audible tone: rise in the 34th cycle after acceptance, 3 rises.
        send(1000, 3, 2);
        wait_idle();

        // Rest tone and all-zero fields.
        send(0, 2, 1);
        wait_idle();
        send(0, 0, 0);
        wait_idle();

        // Back-to-back burst that fills the FIFO.
        for (int i = 0; i < 6; i++) send(1000, 1, 1);
        wait_idle();

        // Divide result 0 clamps to toggle every cycle.
        send(60000, 1, 0);
        wait_idle();

        // Randomized commands with random spacing.
        for (int i = 0; i < 24; i++) begin
            int unsigned f;
            case ($urandom_range(0, 3))
                0:       f = 0;
                1:       f = $urandom_range(1, 2000);
                2:       f = $urandom_range(20000, 65535);
                default: f = 1000;
            endcase
            send(f, $urandom_range(0, 3), $urandom_range(0, 2));
            repeat ($urandom_range(0, 60)) tick();
        end
        wait_idle();

        // Abort mid-tone with two queued entries and a concurrent command.
        for (int i = 0; i < 3; i++) send(500, 3, 1);
        repeat (100) tick();
        abort            = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_freq  = FREQ_W'(700);
        cmd_if.cmd_dur   = DUR_W'(1);
        cmd_if.cmd_gap   = DUR_W'(1);
        tick();
        flush_model();
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        repeat (400) tick();

        // Reset during the gap, then the fresh-start latency again.
        send(1000, 1, 3);
        repeat (233) tick();
        rst = 1'b1;
        tick();
        flush_model();
        rst = 1'b0;
        repeat (5) tick();
        send(1000, 1, 0);
        wait_idle();

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
